// File: rtl/spi_reg_slave.sv
// SPI register-file slave: 2**ADDR_W x DATA_W registers reached over sclk/sen/sdi/sdo.
// Define SPI_REG_SLAVE_ABORTCNT_EN to turn the top address into a read-only aborted-frame counter.
module spi_reg_slave #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 20,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              sen,
   input  logic              sdi,
   output logic              sdo,
   output logic              sdo_oe,
   input  logic [ADDR_W-1:0] loc_addr,
   output logic [DATA_W-1:0] loc_rdata,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);
   localparam int NREG  = 2**ADDR_W;
   localparam int CNT_W = $clog2(ADDR_W + DATA_W + 3);
   // rise numbers (1-based) that close each frame phase
   localparam logic [CNT_W-1:0] R_CMD_LAST = CNT_W'(ADDR_W + 1);
   localparam logic [CNT_W-1:0] R_WR_LAST  = CNT_W'(ADDR_W + DATA_W + 1);
   localparam logic [CNT_W-1:0] R_TURN     = CNT_W'(ADDR_W + 2);
   localparam logic [CNT_W-1:0] R_RD_LAST  = CNT_W'(ADDR_W + DATA_W + 2);

   typedef enum logic [2:0] {IDLE, CMD, WDATA, TURN, RDATA, DONE} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sen_sync_q, sdi_sync_q;
   logic                   sclk_hist_q, sen_hist_q, sdi_hist_q;
   logic                   sclk_rise_q, sclk_fall_q, sen_rise_q, sen_fall_q;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   cmd_q;
   logic [ADDR_W:0]     cmd_d;
   logic [DATA_W-2:0]   wdata_q;
   logic [DATA_W-1:0]   wdata_d;
   logic [DATA_W-1:0]   shadow_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   regs_q [NREG];
   logic                sdo_q, sdo_oe_q, wr_strobe_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [DATA_W-1:0]   wr_data_q, loc_rdata_q;
   logic                wr_ok;

`ifdef SPI_REG_SLAVE_ABORTCNT_EN
   localparam logic [ADDR_W-1:0] TOP_ADDR = '1;
   logic [DATA_W-1:0] abort_cnt_q;
   assign wr_ok = (addr_q != TOP_ADDR);
`else
   assign wr_ok = 1'b1;
`endif

   // Synchronisers plus registered edge pulses; sdi_hist_q is the bit seen at a rise pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         sen_sync_q  <= '0;
         sdi_sync_q  <= '0;
         sclk_hist_q <= 1'b0;
         sen_hist_q  <= 1'b0;
         sdi_hist_q  <= 1'b0;
         sclk_rise_q <= 1'b0;
         sclk_fall_q <= 1'b0;
         sen_rise_q  <= 1'b0;
         sen_fall_q  <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         sen_sync_q  <= {sen_sync_q[SYNC_STAGES-2:0], sen};
         sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
         sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
         sen_hist_q  <= sen_sync_q[SYNC_STAGES-1];
         sdi_hist_q  <= sdi_sync_q[SYNC_STAGES-1];
         sclk_rise_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;
         sclk_fall_q <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_hist_q;
         sen_rise_q  <= sen_sync_q[SYNC_STAGES-1] & ~sen_hist_q;
         sen_fall_q  <= ~sen_sync_q[SYNC_STAGES-1] & sen_hist_q;
      end
   end

   assign cnt_d   = cnt_q + 1'b1;
   assign cmd_d   = {cmd_q, sdi_hist_q};
   assign wdata_d = {wdata_q, sdi_hist_q};

   function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
`ifdef SPI_REG_SLAVE_ABORTCNT_EN
      if (a == TOP_ADDR) return abort_cnt_q;
`endif
      return regs_q[a];
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cmd_q       <= '0;
         wdata_q     <= '0;
         shadow_q    <= '0;
         addr_q      <= '0;
         sdo_q       <= 1'b0;
         sdo_oe_q    <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         loc_rdata_q <= '0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
`ifdef SPI_REG_SLAVE_ABORTCNT_EN
         abort_cnt_q <= '0;
`endif
      end else begin
         wr_strobe_q <= 1'b0;
         loc_rdata_q <= rd_val(loc_addr);
         // abort has priority over any sclk edge seen in the same clk
         if (sen_fall_q && state_q != IDLE && state_q != DONE) begin
            state_q  <= IDLE;
            sdo_oe_q <= 1'b0;
`ifdef SPI_REG_SLAVE_ABORTCNT_EN
            if (abort_cnt_q != '1) abort_cnt_q <= abort_cnt_q + 1'b1;
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  cnt_q <= '0;
                  if (sen_rise_q) state_q <= CMD;
               end
               CMD: if (sclk_rise_q) begin
                  cnt_q <= cnt_d;
                  cmd_q <= cmd_d[ADDR_W-1:0];
                  if (cnt_d == R_CMD_LAST) begin
                     addr_q <= cmd_d[ADDR_W-1:0];
                     if (cmd_d[ADDR_W]) begin
                        state_q  <= TURN;
                        shadow_q <= rd_val(cmd_d[ADDR_W-1:0]);
                     end else begin
                        state_q <= WDATA;
                     end
                  end
               end
               WDATA: if (sclk_rise_q) begin
                  cnt_q   <= cnt_d;
                  wdata_q <= wdata_d[DATA_W-2:0];
                  if (cnt_d == R_WR_LAST) begin
                     state_q <= DONE;
                     if (wr_ok) begin
                        regs_q[addr_q] <= wdata_d;
                        wr_strobe_q    <= 1'b1;
                        wr_addr_q      <= addr_q;
                        wr_data_q      <= wdata_d;
                     end
                  end
               end
               TURN: begin
                  if (sclk_rise_q) begin
                     cnt_q <= cnt_d;
                  end else if (sclk_fall_q && cnt_q == R_TURN) begin
                     sdo_oe_q <= 1'b1;
                     sdo_q    <= shadow_q[DATA_W-1];
                     shadow_q <= {shadow_q[DATA_W-2:0], 1'b0};
                     state_q  <= RDATA;
                  end
               end
               RDATA: begin
                  if (sclk_rise_q) begin
                     cnt_q <= cnt_d;
                  end else if (sclk_fall_q) begin
                     if (cnt_q == R_RD_LAST) begin
                        sdo_oe_q <= 1'b0;
                        state_q  <= DONE;
                     end else begin
                        sdo_q    <= shadow_q[DATA_W-1];
                        shadow_q <= {shadow_q[DATA_W-2:0], 1'b0};
                     end
                  end
               end
               DONE:    if (sen_fall_q) state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign sdo       = sdo_q;
   assign sdo_oe    = sdo_oe_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign loc_rdata = loc_rdata_q;

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- Downstream peer of the 2-wire SPI master: a register-file slave holding 16 x 20-bit registers.
- Consumes sclk/sen/serial data from the master and decodes frames (rw, 4-bit address, 20-bit data).
- Writes the addressed register, or returns its contents on the shared data line during a read frame.
- Exposes a write-notify strobe and a registered local read port to on-chip user logic.

Parameters:
- ADDR_W, 4: address bits; register count = 2**ADDR_W.
- DATA_W, 20: register and data-field width.
- SYNC_STAGES, 2: flip-flop stages synchronising sclk, sen and sdi into clk.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; synchronous, active-low.
- sclk  in  1  serial clock from master, asynchronous to clk.
- sen  in  1  frame enable from master, active-high.
- sdi  in  1  serial data in, from the shared data pin.
- sdo  out  1  serial data out, to the shared data pin.
- sdo_oe  out  1  slave drive enable; the top level builds the inout pin from sdo/sdo_oe.
- loc_addr  in  ADDR_W  local read address.
- loc_rdata  out  DATA_W  reg[loc_addr], one clk latency.
- wr_strobe  out  1  one-clk pulse when an SPI write commits.
- wr_addr  out  ADDR_W  address of the committed write; valid with wr_strobe.
- wr_data  out  DATA_W  data of the committed write; valid with wr_strobe.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All registers to 0; state IDLE; bit counter 0.
  - sdo=0, sdo_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, loc_rdata=0.
  - Reset mid-frame abandons the frame: no commit, sdo_oe drops on the same edge.
- Input synchronisation:
  - sclk, sen, sdi pass through SYNC_STAGES flops plus one history flop, giving rise/fall detect pulses in clk.
  - Required input timing: sclk high and low phases each >= SYNC_STAGES+3 clk (met at 1 MHz sclk / 50 MHz clk).
- Bit sampling: the slave samples sdi on each detected sclk rise. Rises are numbered 1.. from sen assertion.
- Frame layout:
  - rise 1 = rw (0 write, 1 read).
  - rises 2-5 = A3..A0.
  - Write: rises 6-25 = D19..D0.
  - Read: rise 6 = turnaround (sdi ignored); slave drives rises 7-26 = D19..D0.
- States:
  - IDLE: wait for sen rise -> CMD; counter cleared.
  - CMD: shift rw + address over 5 rises. After rise 5: rw=0 -> WDATA; rw=1 -> TURN, and the shadow register loads reg[addr] in that clk.
  - WDATA: shift 20 bits MSB first. After rise 25: commit reg[addr]<=data, then -> DONE. wr_strobe/wr_addr/wr_data assert exactly 1 clk after the rise-25 detect pulse, i.e. SYNC_STAGES+2 clk after the pin edge.
  - TURN: on the sclk fall after rise 6, sdo_oe<=1, sdo<=shadow[19] -> RDATA.
  - RDATA: each subsequent sclk fall shifts the next shadow bit onto sdo. After the fall following rise 26, sdo_oe<=0 -> DONE.
  - DONE: ignore all sclk activity until sen falls -> IDLE.
- Abort: a detected sen fall in any state other than IDLE/DONE -> IDLE.
  - No register change, no wr_strobe.
  - sdo_oe<=0 on the same clk.
- Simultaneous events:
  - sen fall in the same clk as a rise detect: abort wins.
  - An SPI write commit and a local read of the same address in the same clk: loc_rdata returns the old value; the new value appears the following clk.
- sdo_oe never asserts outside RDATA.
- sdo holds its last value when sdo_oe=0 and is don't-care externally.

Optional Feature:
- Macro: SPI_REG_SLAVE_ABORTCNT_EN.
- When defined: the highest address (15) is a read-only DATA_W-bit counter of aborted frames.
  - Increments once per abort and saturates at all-ones.
  - SPI writes to address 15 are dropped: no state change, no wr_strobe.
  - Readable via SPI and loc_rdata.
- When undefined: address 15 is an ordinary read/write register and no counter logic exists.

Test Plan:
- Write 0x5A5A5 to addr 3 -> reg[3]=0x5A5A5; wr_strobe one clk with wr_addr=3, wr_data=0x5A5A5, SYNC_STAGES+2 clk after rise 25; loc_addr=3 gives 0x5A5A5 next clk.
- Write 0xABCDE to addr 9, then read addr 9 -> sdo_oe high from the fall after rise 6 to the fall after rise 26; master captures 0xABCDE; sdo_oe=0 afterwards.
- Write frame to addr 4, sen dropped after rise 12 -> reg[4] unchanged (0), no wr_strobe; with the macro defined, a read of addr 15 returns 1.
- rst_n low during RDATA of a read frame -> sdo_oe=0 next clk, all registers 0; the following full write to addr 0 of 0x00001 commits normally.
- Write frame with 30 sclk rises to addr 7 data 0xFFFFF -> exactly one commit after rise 25; extra rises ignored; reg[7]=0xFFFFF.
- Macro defined, write 0x12345 to addr 15 -> no wr_strobe; read addr 15 returns the abort count (0 after reset).
